// File: rtl/iobus_n_connect_if.sv
// iobus_n_connect_if: APR-side PDP-6 I/O bus between the processor and the
// multi-slot device connector. The master modport is the processor, and the
// slave modport is the connector.
// Optional macro IOBUS_NXD_EN adds the m_nxd nonexistent-device line.
interface iobus_n_connect_if;
    logic        m_iob_poweron;
    logic        m_iob_reset;
    logic        m_datao_clear;
    logic        m_datao_set;
    logic        m_cono_clear;
    logic        m_cono_set;
    logic        m_rdi_pulse;
    logic        m_iob_fm_datai;
    logic        m_iob_fm_status;
    logic [3:9]  m_ios;
    logic [0:35] m_iob_write;
    logic [1:7]  m_pi_req;
    logic [0:35] m_iob_read;
    logic        m_dr_split;
    logic        m_rdi_data;
`ifdef IOBUS_NXD_EN
    logic        m_nxd;
`endif

    modport master (
        output m_iob_poweron, m_iob_reset,
        output m_datao_clear, m_datao_set, m_cono_clear, m_cono_set, m_rdi_pulse,
        output m_iob_fm_datai, m_iob_fm_status, m_ios, m_iob_write,
        input  m_pi_req, m_iob_read, m_dr_split, m_rdi_data
`ifdef IOBUS_NXD_EN
        , input m_nxd
`endif
    );

    modport slave (
        input  m_iob_poweron, m_iob_reset,
        input  m_datao_clear, m_datao_set, m_cono_clear, m_cono_set, m_rdi_pulse,
        input  m_iob_fm_datai, m_iob_fm_status, m_ios, m_iob_write,
        output m_pi_req, m_iob_read, m_dr_split, m_rdi_data
`ifdef IOBUS_NXD_EN
        , output m_nxd
`endif
    );
endinterface

// File: rtl/iobus_n_connect.sv
// iobus_n_connect: connects one PDP-6 I/O bus master to NDEV device slots.
// It decodes the device select, routes strobes to the selected slot only,
// wire-ORs read data with the write data, and merges PI requests.
// All master-facing and per-slot outputs are registered (1-cycle latency).
// Optional macro IOBUS_NXD_EN adds a timeout that pulses m_nxd on unclaimed accesses.
module iobus_n_connect #(
    parameter int          NDEV     = 4,
    parameter logic [55:0] DEVCODES = 56'h0,
    parameter int          TIMEOUT  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    iobus_n_connect_if.slave     apr,
    output logic [NDEV-1:0]      s_iob_poweron,
    output logic [NDEV-1:0]      s_iob_reset,
    output logic [NDEV-1:0]      s_datao_clear,
    output logic [NDEV-1:0]      s_datao_set,
    output logic [NDEV-1:0]      s_cono_clear,
    output logic [NDEV-1:0]      s_cono_set,
    output logic [NDEV-1:0]      s_rdi_pulse,
    output logic [NDEV-1:0]      s_iob_fm_datai,
    output logic [NDEV-1:0]      s_iob_fm_status,
    output logic [6:0]           s_ios,
    output logic [35:0]          s_iob_write,
    input  logic [7*NDEV-1:0]    s_pi_req,
    input  logic [36*NDEV-1:0]   s_iob_read,
    input  logic [NDEV-1:0]      s_dr_split,
    input  logic [NDEV-1:0]      s_rdi_data
);

    // Reject configurations the slot packing or the timeout counter cannot hold.
    generate
        if (NDEV < 1 || NDEV > 8) begin : g_bad_ndev
            $error("iobus_n_connect: NDEV must be in 1..8");
        end
        if (TIMEOUT < 2) begin : g_bad_timeout
            $error("iobus_n_connect: TIMEOUT must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_NXD  = 2'd2
    } state_t;

    // Per-slot line order: datao_clear, datao_set, cono_clear, cono_set,
    // rdi_pulse, fm_datai, fm_status (index 6 down to 0).
    logic [6:0]      lv_s;
    logic            act_s;
    logic [NDEV-1:0] hit_s;
    logic [NDEV-1:0] selnext_s;
    logic [35:0]     rd_or_s;
    logic [6:0]      pi_or_s;

    state_t          state_d, state_q;
    logic [NDEV-1:0] sel_d, sel_q;
    logic [NDEV-1:0] strb_d [7];
    logic [NDEV-1:0] strb_q [7];
    logic [NDEV-1:0] poweron_d, poweron_q;
    logic [NDEV-1:0] ioreset_d, ioreset_q;
    logic [35:0]     read_d, read_q;
    logic [6:0]      pi_d, pi_q;
    logic            dr_split_d, dr_split_q;
    logic            rdi_data_d, rdi_data_q;

`ifdef IOBUS_NXD_EN
    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             nxd_d, nxd_q;
`endif

    assign lv_s  = {apr.m_datao_clear, apr.m_datao_set, apr.m_cono_clear, apr.m_cono_set,
                    apr.m_rdi_pulse, apr.m_iob_fm_datai, apr.m_iob_fm_status};
    assign act_s = |lv_s;

    // Decode the device select; scanning downward lets the lowest matching slot win.
    always_comb begin
        hit_s = '0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            hit_s = (apr.m_ios == DEVCODES[7*i +: 7]) ? (NDEV'(1) << i) : hit_s;
        end
    end

    // Next-state logic: select latching, bus-reset override and unclaimed-access timeout.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        selnext_s = '0;
`ifdef IOBUS_NXD_EN
        cnt_d     = cnt_q;
        nxd_d     = 1'b0;
`endif
        if (apr.m_iob_reset) begin
            state_d   = ST_IDLE;
            sel_d     = '0;
            selnext_s = '0;
`ifdef IOBUS_NXD_EN
            cnt_d     = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sel_d     = hit_s;
                    selnext_s = hit_s;
                    if (act_s && (|hit_s)) begin
                        state_d = ST_BUSY;
                    end else if (act_s) begin
`ifdef IOBUS_NXD_EN
                        state_d = ST_NXD;
                        cnt_d   = '0;
`else
                        state_d = ST_BUSY;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // Select is frozen for the whole access, including the release cycle.
                    selnext_s = sel_q;
                    state_d   = act_s ? ST_BUSY : ST_IDLE;
                end
`ifdef IOBUS_NXD_EN
                ST_NXD: begin
                    sel_d = '0;
                    if (!act_s) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        nxd_d = ((cnt_q + CNT_W'(1)) == CNT_LAST);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    sel_d   = '0;
                end
            endcase
        end
    end

    // Output datapath: gated strobes, broadcasts, wired-OR read data and PI merge.
    always_comb begin
        for (int k = 0; k < 7; k++) begin
            strb_d[k] = lv_s[k] ? selnext_s : '0;
        end
        poweron_d = {NDEV{apr.m_iob_poweron}};
        ioreset_d = {NDEV{apr.m_iob_reset}};
        rd_or_s   = '0;
        pi_or_s   = '0;
        for (int i = 0; i < NDEV; i++) begin
            rd_or_s = rd_or_s | (s_iob_read[36*i +: 36] & {36{sel_q[i]}});
            pi_or_s = pi_or_s | s_pi_req[7*i +: 7];
        end
        read_d     = apr.m_iob_write | rd_or_s;
        pi_d       = pi_or_s;
        dr_split_d = |(sel_q & s_dr_split);
        rdi_data_d = |(sel_q & s_rdi_data);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            for (int k = 0; k < 7; k++) begin
                strb_q[k] <= '0;
            end
            poweron_q  <= '0;
            ioreset_q  <= '0;
            read_q     <= 36'd0;
            pi_q       <= 7'd0;
            dr_split_q <= 1'b0;
            rdi_data_q <= 1'b0;
`ifdef IOBUS_NXD_EN
            cnt_q      <= '0;
            nxd_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            for (int k = 0; k < 7; k++) begin
                strb_q[k] <= strb_d[k];
            end
            poweron_q  <= poweron_d;
            ioreset_q  <= ioreset_d;
            read_q     <= read_d;
            pi_q       <= pi_d;
            dr_split_q <= dr_split_d;
            rdi_data_q <= rdi_data_d;
`ifdef IOBUS_NXD_EN
            cnt_q      <= cnt_d;
            nxd_q      <= nxd_d;
`endif
        end
    end

    assign s_datao_clear   = strb_q[6];
    assign s_datao_set     = strb_q[5];
    assign s_cono_clear    = strb_q[4];
    assign s_cono_set      = strb_q[3];
    assign s_rdi_pulse     = strb_q[2];
    assign s_iob_fm_datai  = strb_q[1];
    assign s_iob_fm_status = strb_q[0];
    assign s_iob_poweron   = poweron_q;
    assign s_iob_reset     = ioreset_q;
    assign s_ios           = apr.m_ios;
    assign s_iob_write     = apr.m_iob_write;
    assign apr.m_iob_read  = read_q;
    assign apr.m_pi_req    = pi_q;
    assign apr.m_dr_split  = dr_split_q;
    assign apr.m_rdi_data  = rdi_data_q;
`ifdef IOBUS_NXD_EN
    assign apr.m_nxd       = nxd_q;
`endif

endmodule

// File: tb/tb_iobus_n_connect.sv
// tb_iobus_n_connect: directed, table-driven bench for iobus_n_connect with
// four slots on codes 070/074/120/124. Build with IOBUS_NXD_EN to cover m_nxd.
module tb_iobus_n_connect;
    localparam int          NDEV    = 4;
    localparam int          TIMEOUT = 16;
    localparam logic [55:0] CODES   = {28'd0, 7'o124, 7'o120, 7'o074, 7'o070};

    localparam logic [6:0] L_NONE  = 7'b0000000;
    localparam logic [6:0] L_DSET  = 7'b0100000;
    localparam logic [6:0] L_CCLR  = 7'b0010000;
    localparam logic [6:0] L_CSET  = 7'b0001000;
    localparam logic [6:0] L_RDI   = 7'b0000100;
    localparam logic [6:0] L_DATAI = 7'b0000010;
    localparam logic [6:0] L_STAT  = 7'b0000001;

    localparam logic [35:0] RD0 = 36'o100000000000;
    localparam logic [35:0] RD1 = 36'o777000000000;
    localparam logic [35:0] RD2 = 36'o000000770000;
    localparam logic [35:0] RD3 = 36'o000000000400;
    localparam logic [3:0]  DRS = 4'b0101;
    localparam logic [3:0]  RDD = 4'b1010;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    iobus_n_connect_if bus();

    logic [NDEV-1:0]    s_iob_poweron, s_iob_reset;
    logic [NDEV-1:0]    s_datao_clear, s_datao_set, s_cono_clear, s_cono_set;
    logic [NDEV-1:0]    s_rdi_pulse, s_iob_fm_datai, s_iob_fm_status;
    logic [6:0]         s_ios;
    logic [35:0]        s_iob_write;
    logic [7*NDEV-1:0]  s_pi_req;
    logic [36*NDEV-1:0] s_iob_read;
    logic [NDEV-1:0]    s_dr_split, s_rdi_data;
    logic [NDEV-1:0]    got_strb [7];

    iobus_n_connect #(.NDEV(NDEV), .DEVCODES(CODES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .apr(bus),
        .s_iob_poweron(s_iob_poweron), .s_iob_reset(s_iob_reset),
        .s_datao_clear(s_datao_clear), .s_datao_set(s_datao_set),
        .s_cono_clear(s_cono_clear), .s_cono_set(s_cono_set),
        .s_rdi_pulse(s_rdi_pulse), .s_iob_fm_datai(s_iob_fm_datai),
        .s_iob_fm_status(s_iob_fm_status), .s_ios(s_ios), .s_iob_write(s_iob_write),
        .s_pi_req(s_pi_req), .s_iob_read(s_iob_read),
        .s_dr_split(s_dr_split), .s_rdi_data(s_rdi_data)
    );

    assign got_strb[6] = s_datao_clear;
    assign got_strb[5] = s_datao_set;
    assign got_strb[4] = s_cono_clear;
    assign got_strb[3] = s_cono_set;
    assign got_strb[2] = s_rdi_pulse;
    assign got_strb[1] = s_iob_fm_datai;
    assign got_strb[0] = s_iob_fm_status;

    typedef struct {
        logic [6:0]  ios;
        logic [6:0]  lv;
        logic        pwr;
        logic        iorst;
        logic [35:0] wr;
        logic [3:0]  exp_sel;   // slots that must see each active line
        logic [3:0]  exp_rsel;  // slot whose read/dr/rdi data must appear
    } vec_t;

    vec_t vecs [17];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] ios, input logic [6:0] lv, input logic pwr,
                                input logic iorst, input logic [35:0] wr,
                                input logic [3:0] es, input logic [3:0] er);
        vec_t v;
        v.ios = ios; v.lv = lv; v.pwr = pwr; v.iorst = iorst; v.wr = wr;
        v.exp_sel = es; v.exp_rsel = er;
        return v;
    endfunction

    function automatic logic [35:0] exp_read(input logic [35:0] wr, input logic [3:0] rsel);
        logic [35:0] r;
        r = wr;
        if (rsel[0]) r = r | RD0;
        if (rsel[1]) r = r | RD1;
        if (rsel[2]) r = r | RD2;
        if (rsel[3]) r = r | RD3;
        return r;
    endfunction

    task automatic drive(input logic [6:0] ios, input logic [6:0] lv, input logic pwr,
                         input logic iorst, input logic [35:0] wr);
        bus.m_ios         = ios;
        {bus.m_datao_clear, bus.m_datao_set, bus.m_cono_clear, bus.m_cono_set,
         bus.m_rdi_pulse, bus.m_iob_fm_datai, bus.m_iob_fm_status} = lv;
        bus.m_iob_poweron = pwr;
        bus.m_iob_reset   = iorst;
        bus.m_iob_write   = wr;
    endtask

    initial begin
        // Reset with busy-looking inputs: registered outputs must still be 0.
        reset      = 1'b1;
        drive(7'o120, L_DSET, 1'b1, 1'b1, 36'o123456701234);
        s_pi_req   = {7'b1111111, 7'b0, 7'b0, 7'b1010101};
        s_iob_read = {RD3, RD2, RD1, RD0};
        s_dr_split = DRS;
        s_rdi_data = RDD;
        repeat (2) @(posedge clk);
        #1;
        check("rst strobes", {s_datao_clear, s_datao_set, s_cono_clear, s_cono_set,
                              s_rdi_pulse, s_iob_fm_datai, s_iob_fm_status}, 64'd0);
        check("rst bcast", {s_iob_poweron, s_iob_reset}, 64'd0);
        check("rst read", bus.m_iob_read, 64'd0);
        check("rst pi/dr/rdi", {bus.m_pi_req, bus.m_dr_split, bus.m_rdi_data}, 64'd0);
`ifdef IOBUS_NXD_EN
        check("rst nxd", bus.m_nxd, 64'd0);
`endif
        @(negedge clk);
        reset    = 1'b0;
        s_pi_req = '0;
        drive(7'o000, L_NONE, 1'b0, 1'b0, 36'd0);

        //             ios     lv             pwr   iorst wr                 sel      rsel
        vecs[0]  = mk(7'o120, L_NONE,         1'b0, 1'b0, 36'd0,            4'b0100, 4'b0000);
        vecs[1]  = mk(7'o120, L_DSET,         1'b0, 1'b0, 36'o123456701234, 4'b0100, 4'b0100);
        vecs[2]  = mk(7'o120, L_NONE,         1'b0, 1'b0, 36'd0,            4'b0000, 4'b0100);
        vecs[3]  = mk(7'o074, L_NONE,         1'b0, 1'b0, 36'd0,            4'b0000, 4'b0100);
        vecs[4]  = mk(7'o074, L_DATAI,        1'b0, 1'b0, 36'o000000000017, 4'b0010, 4'b0010);
        vecs[5]  = mk(7'o120, L_DATAI,        1'b0, 1'b0, 36'o000000000017, 4'b0010, 4'b0010);
        vecs[6]  = mk(7'o120, L_DATAI,        1'b0, 1'b0, 36'o000000000017, 4'b0010, 4'b0010);
        vecs[7]  = mk(7'o120, L_NONE,         1'b0, 1'b0, 36'd0,            4'b0000, 4'b0010);
        vecs[8]  = mk(7'o070, L_NONE,         1'b0, 1'b0, 36'd0,            4'b0000, 4'b0010);
        vecs[9]  = mk(7'o070, L_CSET|L_CCLR,  1'b0, 1'b0, 36'd0,            4'b0001, 4'b0001);
        vecs[10] = mk(7'o070, L_CSET,         1'b0, 1'b1, 36'd0,            4'b0000, 4'b0001);
        vecs[11] = mk(7'o124, L_CSET,         1'b0, 1'b0, 36'd0,            4'b1000, 4'b0000);
        vecs[12] = mk(7'o124, L_NONE,         1'b0, 1'b0, 36'd0,            4'b0000, 4'b1000);
        vecs[13] = mk(7'o070, L_RDI,          1'b1, 1'b0, 36'd0,            4'b0001, 4'b1000);
        vecs[14] = mk(7'o070, L_NONE,         1'b0, 1'b0, 36'd0,            4'b0000, 4'b0001);
        vecs[15] = mk(7'o074, L_NONE,         1'b0, 1'b0, 36'd0,            4'b0000, 4'b0001);
        vecs[16] = mk(7'o074, L_NONE,         1'b0, 1'b0, 36'd0,            4'b0000, 4'b0010);

        for (int n = 0; n < 17; n++) begin
            @(negedge clk);
            drive(vecs[n].ios, vecs[n].lv, vecs[n].pwr, vecs[n].iorst, vecs[n].wr);
            @(posedge clk);
            #1;
            for (int k = 0; k < 7; k++) begin
                check($sformatf("v%0d strobe%0d", n, k), got_strb[k],
                      vecs[n].lv[k] ? vecs[n].exp_sel : 4'b0000);
            end
            check($sformatf("v%0d poweron", n), s_iob_poweron, {4{vecs[n].pwr}});
            check($sformatf("v%0d iob_reset", n), s_iob_reset, {4{vecs[n].iorst}});
            check($sformatf("v%0d read", n), bus.m_iob_read, exp_read(vecs[n].wr, vecs[n].exp_rsel));
            check($sformatf("v%0d dr_split", n), bus.m_dr_split, |(vecs[n].exp_rsel & DRS));
            check($sformatf("v%0d rdi_data", n), bus.m_rdi_data, |(vecs[n].exp_rsel & RDD));
            check($sformatf("v%0d pass", n), {s_ios, s_iob_write}, {vecs[n].ios, vecs[n].wr});
            check($sformatf("v%0d pi", n), bus.m_pi_req, 64'd0);
        end

        // PI merge: independent of selection, one cycle of latency.
        @(negedge clk);
        drive(7'o000, L_NONE, 1'b0, 1'b0, 36'd0);
        s_pi_req = {7'b1000000, 7'b0000000, 7'b0000000, 7'b0000100};
        #1;
        check("pi before edge", bus.m_pi_req, 64'd0);
        @(posedge clk);
        #1;
        check("pi merged", bus.m_pi_req, 64'b1000100);
        @(negedge clk);
        s_pi_req = '0;

        // Unclaimed access on code 177: loopback only, no slot strobes.
        drive(7'o177, L_NONE, 1'b0, 1'b0, 36'd0);
        @(negedge clk);
        drive(7'o177, L_STAT, 1'b0, 1'b0, 36'o525252525252);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("nxd c%0d strobes", n),
                  s_datao_clear | s_datao_set | s_cono_clear | s_cono_set |
                  s_rdi_pulse | s_iob_fm_datai | s_iob_fm_status, 64'd0);
            check($sformatf("nxd c%0d read", n), bus.m_iob_read, 36'o525252525252);
`ifdef IOBUS_NXD_EN
            check($sformatf("nxd c%0d pulse", n), bus.m_nxd, (n == 16) ? 64'd1 : 64'd0);
`endif
        end
        @(negedge clk);
        drive(7'o177, L_NONE, 1'b0, 1'b0, 36'd0);
        @(posedge clk);
        #1;
        check("nxd release read", bus.m_iob_read, 64'd0);
`ifdef IOBUS_NXD_EN
        check("nxd release pulse", bus.m_nxd, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
